// File: rtl/cpu6502_sprite_dma.sv
// Sprite DMA bridge between a 6502 core and the system bus.
// The bridge passes CPU cycles straight through until the core writes the trigger
// address. It then halts the core and copies one 256-byte page to a fixed
// destination port, one read/write pair per bus tick. The halt lasts 513 or 514
// ticks, matching the classic OAM-DMA peripheral.
module cpu6502_sprite_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004,
    parameter bit          ALIGN_ENABLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] cpuAddress,
    input  logic [7:0]  cpuDataOut,
    input  logic        cpuWriteEnable,
    output logic [7:0]  cpuDataIn,
    output logic        cpuEnable,
    output logic [15:0] busAddress,
    output logic [7:0]  busDataOut,
    output logic        busWriteEnable,
    input  logic [7:0]  busDataIn,
    output logic        dmaActive
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] latch_q, latch_d;
    logic       parity_q, parity_d;

    // State register: reset has priority over everything, including a trigger tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            latch_q  <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            latch_q  <= latch_d;
            parity_q <= parity_d;
        end
    end

    // Next-state logic: nothing moves unless the bus tick is high.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        latch_d  = latch_q;
        parity_d = parity_q;
        if (tick) begin
            parity_d = ~parity_q;
            case (state_q)
                IDLE: begin
                    if (cpuWriteEnable && (cpuAddress == TRIGGER_ADDR)) begin
                        state_d = HALT;
                        page_d  = cpuDataOut;
                        index_d = 8'h00;
                    end
                end
                // Parity seen during HALT decides the alignment slot.
                // READ must start on a tick where parity is 0.
                HALT:  state_d = (ALIGN_ENABLE && !parity_q) ? ALIGN : READ;
                ALIGN: state_d = READ;
                READ: begin
                    latch_d = busDataIn;
                    state_d = WRITE;
                end
                WRITE: begin
                    // Index wraps inside the page; it never carries into the page byte.
                    index_d = index_q + 8'h01;
                    state_d = (index_q == 8'hFF) ? IDLE : READ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: pass-through in IDLE, DMA-owned bus otherwise.
    always_comb begin
        cpuDataIn      = busDataIn;
        dmaActive      = (state_q != IDLE);
        cpuEnable      = 1'b0;
        busAddress     = cpuAddress;
        busDataOut     = latch_q;
        busWriteEnable = 1'b0;
        case (state_q)
            IDLE: begin
                cpuEnable      = tick;
                busDataOut     = cpuDataOut;
                busWriteEnable = cpuWriteEnable & tick;
            end
            READ: begin
                busAddress = {page_q, index_q};
            end
            WRITE: begin
                busAddress     = DEST_ADDR;
                busWriteEnable = tick;
            end
            default: begin
                // HALT/ALIGN issue a dummy read at whatever address the core holds.
                busAddress = cpuAddress;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu6502_sprite_dma.sv
// Directed bench for cpu6502_sprite_dma. Instance A uses the default alignment
// setting and instance B has alignment disabled. Both instances share the CPU-side
// stimulus, and each one reads its own model memory.
module tb_cpu6502_sprite_dma;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic        cpu_we;

    logic [7:0]  cpu_din_a, cpu_din_b, bus_dout_a, bus_dout_b, bus_din_a, bus_din_b;
    logic        cpu_en_a, cpu_en_b, bus_we_a, bus_we_b, dma_a, dma_b;
    logic [15:0] bus_addr_a, bus_addr_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic tb_par;
    logic sel_b;

    always #5 clock = ~clock;

    // Model memory: page 80 reads back A9; every other location reads low-byte ^ 5A.
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (a[15:8] == 8'h80) return 8'hA9;
        return a[7:0] ^ 8'h5A;
    endfunction

    assign bus_din_a = mem_rd(bus_addr_a);
    assign bus_din_b = mem_rd(bus_addr_b);

    cpu6502_sprite_dma dut_a (
        .clock(clock), .reset(reset), .tick(tick),
        .cpuAddress(cpu_address), .cpuDataOut(cpu_data_out), .cpuWriteEnable(cpu_we),
        .cpuDataIn(cpu_din_a), .cpuEnable(cpu_en_a),
        .busAddress(bus_addr_a), .busDataOut(bus_dout_a), .busWriteEnable(bus_we_a),
        .busDataIn(bus_din_a), .dmaActive(dma_a)
    );

    cpu6502_sprite_dma #(.ALIGN_ENABLE(1'b0)) dut_b (
        .clock(clock), .reset(reset), .tick(tick),
        .cpuAddress(cpu_address), .cpuDataOut(cpu_data_out), .cpuWriteEnable(cpu_we),
        .cpuDataIn(cpu_din_b), .cpuEnable(cpu_en_b),
        .busAddress(bus_addr_b), .busDataOut(bus_dout_b), .busWriteEnable(bus_we_b),
        .busDataIn(bus_din_b), .dmaActive(dma_b)
    );

    // Selected-instance view.
    logic [15:0] s_addr;
    logic [7:0]  s_dout, s_cdin;
    logic        s_en, s_we, s_dma;
    assign s_addr = sel_b ? bus_addr_b : bus_addr_a;
    assign s_dout = sel_b ? bus_dout_b : bus_dout_a;
    assign s_cdin = sel_b ? cpu_din_b  : cpu_din_a;
    assign s_en   = sel_b ? cpu_en_b   : cpu_en_a;
    assign s_we   = sel_b ? bus_we_b   : bus_we_a;
    assign s_dma  = sel_b ? dma_b      : dma_a;

    // Tick parity as seen by the block: cleared by reset, flipped by every tick.
    always @(posedge clock) begin
        if (reset) tb_par <= 1'b0;
        else if (tick) tb_par <= ~tb_par;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_drive();
        cpu_address  = 16'h1234;
        cpu_data_out = 8'hEE;
        cpu_we       = 1'b0;
        tick         = 1'b1;
    endtask

    // Trigger a copy of page pg and follow it until the core is released.
    // want_par is the tick parity wanted at the trigger tick (-1 means any).
    // When abort is set, return right after the write with index 40 is seen.
    task automatic run_xfer(input logic b, input logic [7:0] pg, input int want_par,
                            input int exp_halt, input bit gate, input bit abort);
        int halted = 0, wr_cnt = 0, rd_cnt = 0, wr_err = 0, rd_err = 0, g_err = 0;
        bit done = 0, gated = 0;
        logic [15:0] frz;
        sel_b = b;
        step();
        if (want_par >= 0 && tb_par != want_par[0]) begin
            idle_drive();
            @(negedge clock);
            step();
        end
        cpu_address  = 16'h4014;
        cpu_data_out = pg;
        cpu_we       = 1'b1;
        tick         = 1'b1;
        @(negedge clock);
        chk("trig_pass_we", s_we, 1);
        chk("trig_pass_addr", s_addr, 16'h4014);
        for (int c = 0; c < 1200 && !done; c++) begin
            step();
            idle_drive();
            @(negedge clock);
            if (!s_dma) begin
                chk("release_en", s_en, 1);
                done = 1;
            end else begin
                if (!s_en) halted++;
                if (s_we) begin
                    if (s_addr != 16'h2004 || s_dout != (wr_cnt[7:0] ^ 8'h5A)) wr_err++;
                    wr_cnt++;
                end else if (s_addr != 16'h1234) begin
                    if (s_addr != {pg, rd_cnt[7:0]}) rd_err++;
                    rd_cnt++;
                end
                if (abort && wr_cnt == 8'h41) begin
                    chk("abort_wr_err", wr_err, 0);
                    return;
                end
                if (gate && !gated && wr_cnt == 100) begin
                    gated = 1;
                    for (int g = 0; g < 10; g++) begin
                        step();
                        tick = 1'b0;
                        @(negedge clock);
                        if (g == 0) frz = s_addr;
                        if (s_we || !s_dma || s_en || s_addr != frz) g_err++;
                    end
                end
            end
        end
        chk("xfer_done", done, 1);
        chk("halt_ticks", halted, exp_halt);
        chk("write_count", wr_cnt, 256);
        chk("write_data_err", wr_err, 0);
        chk("read_count", rd_cnt, 256);
        chk("read_addr_err", rd_err, 0);
        if (gate) chk("gate_frozen_err", g_err, 0);
    endtask

    initial begin
        int dw;
        sel_b        = 1'b0;
        reset        = 1'b1;
        tick         = 1'b1;
        cpu_address  = 16'h8000;
        cpu_data_out = 8'h00;
        cpu_we       = 1'b0;
        step();
        step();
        @(negedge clock);
        chk("rst_dma", dma_a, 0);
        chk("rst_en", cpu_en_a, 1);
        chk("rst_addr", bus_addr_a, 16'h8000);

        // CPU read of 8000 passes straight through.
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("pt_addr", bus_addr_a, 16'h8000);
        chk("pt_cdin", cpu_din_a, 8'hA9);
        chk("pt_en", cpu_en_a, 1);
        chk("pt_dma", dma_a, 0);
        chk("pt_we", bus_we_a, 0);
        step();
        tick = 1'b0;
        @(negedge clock);
        chk("pt_en_notick", cpu_en_a, 0);

        // Parity 1 during HALT gives no align slot; parity 0 gives one.
        run_xfer(1'b0, 8'h02, 0, 513, 1'b0, 1'b0);
        run_xfer(1'b0, 8'h02, 1, 514, 1'b0, 1'b0);
        // A 10-clock tick stall mid-transfer leaves the halt length unchanged.
        run_xfer(1'b0, 8'h02, 0, 513, 1'b1, 1'b0);

        // Reset while WRITE holds index 40: the transfer is abandoned.
        run_xfer(1'b0, 8'h03, -1, 0, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_drive();
        @(negedge clock);
        chk("abort_dma", dma_a, 0);
        chk("abort_en", cpu_en_a, 1);
        chk("abort_addr", bus_addr_a, 16'h1234);
        dw = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clock);
            if (bus_we_a || dma_a) dw++;
        end
        chk("abort_no_writes", dw, 0);
        run_xfer(1'b0, 8'h04, 0, 513, 1'b0, 1'b0);

        // A reset in the same cycle as a trigger tick wins.
        step();
        reset        = 1'b1;
        cpu_address  = 16'h4014;
        cpu_data_out = 8'h05;
        cpu_we       = 1'b1;
        step();
        reset = 1'b0;
        idle_drive();
        @(negedge clock);
        chk("rst_trig_dma", dma_a, 0);

        // With alignment disabled, page FF takes 513 ticks at either parity.
        run_xfer(1'b1, 8'hFF, 0, 513, 1'b0, 1'b0);
        run_xfer(1'b1, 8'hFF, 1, 513, 1'b0, 1'b0);

        // A write to 4015 is not a trigger.
        step();
        cpu_address  = 16'h4015;
        cpu_data_out = 8'h77;
        cpu_we       = 1'b1;
        @(negedge clock);
        chk("nt_we", bus_we_b, 1);
        chk("nt_addr", bus_addr_b, 16'h4015);
        chk("nt_dout", bus_dout_b, 8'h77);
        step();
        idle_drive();
        @(negedge clock);
        chk("nt_dma", dma_b, 0);
        chk("nt_en", cpu_en_b, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
